ps2_key_event_ctrl: RTL
=======================

// Module: ps2_key_event_ctrl
// PURPOSE
//   Sits between PS2_Controller (received_data/received_data_en) and the Simon game FSM.
//   Parses the scancode stream: E0 extended prefix, F0 break prefix, make codes.
//   Tracks which of six game keys are held and suppresses typematic repeats.
//   Queues one event per new key press in a FIFO drained by a valid/ready handshake.
// PARAMETERS
//   FIFO_DEPTH      4          event queue depth; power of 2, >=2
//   TIMEOUT_CYCLES  2_500_000  max CLOCK_50 cycles after a prefix byte before abandoning the frame (50 ms)
// PORTS
//   CLOCK_50   in   1  system clock, 50 MHz
//   reset      in   1  asynchronous, active-high reset
//   rx_data    in   8  scancode byte from PS2_Controller
//   rx_valid   in   1  one-cycle strobe; rx_data valid on that cycle
//   flush      in   1  synchronous; empties the event FIFO
//   evt_ready  in   1  consumer accepts the head event
//   evt_valid  out  1  FIFO not empty
//   evt_code   out  3  head key index: 0 up, 1 down, 2 left, 3 right, 4 enter, 5 space
//   held       out  6  bit k = key k currently held
//   overflow   out  1  sticky; set when a press event is dropped; cleared only by reset
//   frame_err  out  1  one-cycle pulse on prefix timeout or illegal byte in S_BRK
// BEHAVIOUR
//   Reset (async, active-high): state=S_IDLE, timer=0, held=0, FIFO empty,
//     evt_valid=0, evt_code=0, overflow=0, frame_err=0.
//   Key map, E0 ignored for mapping: 75->0, 72->1, 6B->2, 74->3, 5A->4, 29->5.
//     All other codes are unmapped and ignored (no event, no error).
//   FSM advances only on rx_valid:
//     S_IDLE: E0->S_EXT; F0->S_BRK; other->MAKE(code), stay in S_IDLE.
//     S_EXT : E0->S_EXT; F0->S_BRK; other->MAKE(code), then S_IDLE.
//     S_BRK : E0 or F0->frame_err pulse, then S_IDLE; other->BREAK(code), then S_IDLE.
//   Timer:
//     - Cleared on entry to S_EXT/S_BRK and on every rx_valid.
//     - Counts each cycle while in S_EXT/S_BRK without rx_valid.
//     - Reaching TIMEOUT_CYCLES-1 -> frame_err pulse, S_IDLE, no MAKE/BREAK.
//     - Width $clog2(TIMEOUT_CYCLES); never wraps.
//   MAKE(k), mapped key:
//     - held[k]=0: set held[k] and push k.
//     - held[k]=1 (typematic repeat): no push.
//   BREAK(k), mapped key: clear held[k]; no push. BREAK of a key not held is a no-op.
//   Latency: rx_valid at cycle N -> held and FIFO updated at N+1.
//     When the FIFO was empty, evt_valid=1 and evt_code=k at N+1.
//   Handshake:
//     - Pop occurs when evt_valid & evt_ready.
//     - evt_code shows the head, registered; it is stable while evt_valid & !evt_ready.
//   FIFO boundaries:
//     - Push while full, no pop: event dropped, overflow<=1, held still updated.
//     - Push and pop same cycle: both succeed, including when full. Count unchanged.
//     - Pop while empty: ignored.
//     - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//   flush: FIFO empty next cycle. A push on the same cycle is discarded.
//     flush does not alter held, FSM or overflow.
//   Reset asserted mid-frame or mid-handshake: all state cleared immediately.
//     After release, the first byte is parsed from S_IDLE.
// TESTING
//   T1 make: 75 -> evt_valid=1, evt_code=0, held=000001 one cycle later.
//      evt_ready=1 -> evt_valid=0.
//   T2 typematic: 6B,6B,6B then F0,6B -> exactly one event code 2.
//      held[2] goes 1 then 0. Sequence E0,74 -> event code 3.
//   T3 overflow, evt_ready=0: 75,72,6B,74,5A makes -> 4 queued, overflow=1, held=011111.
//      Drain order is 0,1,2,3.
//   T4 full+simultaneous: FIFO full, evt_ready=1 on the same cycle as 29 make
//      -> count stays 4, overflow stays 0, the last drained code is 5.
//   T5 timeout: TIMEOUT_CYCLES=16, send E0 then idle 16 cycles -> one frame_err pulse, S_IDLE.
//      Next 5A -> event code 4. Also F0,F0 -> frame_err pulse.
//   T6 reset: reset pulsed with FIFO non-empty and state S_BRK -> all outputs 0.
//      A following 6B (no F0) -> event code 2.

Source files
------------

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
//   Turns the PS/2 scancode byte stream into one event per new press of six
//   game keys. It handles E0/F0 prefixes, tracks held keys and suppresses
//   typematic repeats. Events wait in a small FIFO that the consumer drains
//   with a valid/ready handshake.
// Ports
//   CLOCK_50   in   system clock
//   reset      in   asynchronous, active-high reset
//   rx_data    in   scancode byte, qualified by rx_valid
//   rx_valid   in   one-cycle byte strobe
//   flush      in   synchronous FIFO clear (held/FSM/overflow untouched)
//   evt_ready  in   consumer accepts head event
//   evt_valid  out  FIFO not empty
//   evt_code   out  head key index (0 up,1 down,2 left,3 right,4 enter,5 space)
//   held       out  bit k = key k currently held
//   overflow   out  sticky, a press event was dropped on a full FIFO
//   frame_err  out  one-cycle pulse on prefix timeout or bad byte after F0
module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 2_500_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       flush,
   input  logic       evt_ready,
   output logic       evt_valid,
   output logic [2:0] evt_code,
   output logic [5:0] held,
   output logic       overflow,
   output logic       frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK} state_t;

   state_t        r_state;
   logic [TW-1:0] r_timer;
   logic [5:0]    r_held;
   logic          r_frame_err;

   logic [2:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [2:0]    r_evt_code;
   logic          r_overflow;

   logic          w_mapped;
   logic [2:0]    w_key;
   logic          w_is_e0;
   logic          w_is_f0;
   logic          w_push_req;
   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic [AW-1:0] w_rd_next;
   logic [CW-1:0] w_count_next;
   logic [2:0]    w_next_head;

   // Key map; E0 is not part of the mapping, so extended arrows map like plain ones.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_mapped = 1'b1;
      w_key    = 3'd0;
      case (rx_data)
         8'h75:   w_key = 3'd0;
         8'h72:   w_key = 3'd1;
         8'h6B:   w_key = 3'd2;
         8'h74:   w_key = 3'd3;
         8'h5A:   w_key = 3'd4;
         8'h29:   w_key = 3'd5;
         default: w_mapped = 1'b0;
      endcase
   end

   assign w_is_e0 = (rx_data == 8'hE0);
   assign w_is_f0 = (rx_data == 8'hF0);

   // A make code (mapped codes are never E0/F0) outside S_BRK is a press;
   // only the first press of a held key produces an event.
   assign w_push_req = rx_valid && w_mapped && (r_state != S_BRK) && !r_held[w_key];

   // Parser FSM, prefix timer, held-key map and frame error pulse.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_timer     <= '0;
         r_held      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= 1'b0;
         if (rx_valid) begin
            r_timer <= '0;
            case (r_state)
               S_BRK: begin
                  if (w_is_e0 || w_is_f0) r_frame_err <= 1'b1;
                  else if (w_mapped)      r_held[w_key] <= 1'b0;
                  r_state <= S_IDLE;
               end
               default: begin
                  if (w_is_e0)       r_state <= S_EXT;
                  else if (w_is_f0)  r_state <= S_BRK;
                  else begin
                     r_state <= S_IDLE;
                     if (w_mapped) r_held[w_key] <= 1'b1;
                  end
               end
            endcase
         end else if (r_state != S_IDLE) begin
            // Abandon a half-received frame rather than misread the next byte.
            if (r_timer == TIMER_MAX) begin
               r_frame_err <= 1'b1;
               r_state     <= S_IDLE;
               r_timer     <= '0;
            end else begin
               r_timer <= r_timer + TW'(1);
            end
         end
      end
   end

   // Event FIFO
   assign w_full       = (r_count == CW'(FIFO_DEPTH));
   assign w_pop        = (r_count != '0) && evt_ready;
   // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
   assign w_push       = w_push_req && !flush && (!w_full || w_pop);
   assign w_rd_next    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
   // Forward the pushed code when it lands in the slot that becomes the head.
   assign w_next_head  = (w_push && (r_wr_ptr == w_rd_next)) ? w_key : r_mem[w_rd_next];

   // NOTE: the storage array has no reset; only pointers/count gate what is visible.
   always_ff @(posedge CLOCK_50) begin
      if (w_push) r_mem[r_wr_ptr] <= w_key;
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_evt_code <= '0;
         r_overflow <= 1'b0;
      end else if (flush) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_evt_code <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         r_rd_ptr <= w_rd_next;
         r_count  <= w_count_next;
         r_evt_code <= (w_count_next == '0) ? 3'd0 : w_next_head;
         if (w_push_req && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign evt_valid = (r_count != '0);
   assign evt_code  = r_evt_code;
   assign held      = r_held;
   assign overflow  = r_overflow;
   assign frame_err = r_frame_err;

endmodule
